// File: rtl/ins_responder.sv
// ins_responder: wait-stated instruction store answering a CPU fetch bus, loaded by a boot loader.
// Define INS_RESPONDER_ERR_EN to reject fetches whose address lies beyond the store instead of aliasing.
module ins_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [3:0]  RESET_WAIT = 4'd0
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_res_i,
  input  logic [14:0]           ins_adr_i,
  input  logic                  ins_cyc_i,
  input  logic                  shr_stb_i,
  output logic [15:0]           ins_dat_o,
  output logic                  shr_ack_o,
  output logic                  shr_err_o,
  input  logic                  ldr_we_i,
  input  logic [DEPTH_LOG2-1:0] ldr_adr_i,
  input  logic [15:0]           ldr_dat_i,
  input  logic                  wst_we_i,
  input  logic [3:0]            wst_dat_i
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state, state_nx;
  logic [15:0] mem [1<<DEPTH_LOG2];
  logic [15:0] dat;
  logic [14:0] adr_q;
  logic [3:0] cnt, wait_reg;
  logic go, oor;
  logic [DEPTH_LOG2-1:0] idx;
  assign go = ins_cyc_i & shr_stb_i;
  // the fetch entering ACK straight from IDLE uses the address being latched on that same edge
  assign idx = (state == IDLE) ? ins_adr_i[DEPTH_LOG2-1:0] : adr_q[DEPTH_LOG2-1:0];
`ifdef INS_RESPONDER_ERR_EN
  assign oor = |adr_q[14:DEPTH_LOG2];
`else
  logic unused_hi;
  assign oor = 1'b0;
  assign unused_hi = ^adr_q[14:DEPTH_LOG2];
`endif
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE)
      state_nx = go ? ((wait_reg != 4'd0) ? WAIT : ACK) : IDLE;
    else if (state == WAIT)
      state_nx = !go ? IDLE : ((cnt == 4'd1) ? ACK : WAIT);
  end
  always_ff @(posedge sys_clk_i) begin
    if (!sys_res_i) begin
      state <= IDLE;
      cnt <= 4'd0;
      wait_reg <= RESET_WAIT;
      dat <= 16'h0000;
      adr_q <= 15'h0000;
    end else begin
      state <= state_nx;
      if (wst_we_i) wait_reg <= wst_dat_i;
      if (state == IDLE && go) begin
        adr_q <= ins_adr_i;
        cnt <= wait_reg;
      end else if (state == WAIT) begin
        cnt <= go ? cnt - 4'd1 : 4'd0;
      end
      if (state_nx == ACK) dat <= mem[idx];
    end
  end
  // store is never reset so a reset mid-fetch keeps the loaded program
  always_ff @(posedge sys_clk_i)
    if (ldr_we_i) mem[ldr_adr_i] <= ldr_dat_i;
  assign shr_ack_o = (state == ACK) && !oor;
  assign shr_err_o = (state == ACK) && oor;
  assign ins_dat_o = shr_ack_o ? dat : 16'h0000;
endmodule

// File: tb/tb_ins_responder.sv
// tb_ins_responder: directed checks of fetch latency, aborts, wait-register timing, reset and address range.
module tb_ins_responder;
  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic [14:0] adr = '0;
  logic        cyc = 1'b0, stb = 1'b0;
  logic [15:0] dat;
  logic        ack, err;
  logic        ldr_we = 1'b0;
  logic [9:0]  ldr_adr = '0;
  logic [15:0] ldr_dat = '0;
  logic        wst_we = 1'b0;
  logic [3:0]  wst_dat = '0;
  int n_chk = 0, n_fail = 0;

  ins_responder #(.DEPTH_LOG2(10), .RESET_WAIT(4'd0)) dut (
    .sys_clk_i(clk), .sys_res_i(res), .ins_adr_i(adr), .ins_cyc_i(cyc),
    .shr_stb_i(stb), .ins_dat_o(dat), .shr_ack_o(ack), .shr_err_o(err),
    .ldr_we_i(ldr_we), .ldr_adr_i(ldr_adr), .ldr_dat_i(ldr_dat),
    .wst_we_i(wst_we), .wst_dat_i(wst_dat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic a, input logic e, input logic [15:0] d);
    chk({tag, "_ack"}, {15'h0, ack}, {15'h0, a});
    chk({tag, "_err"}, {15'h0, err}, {15'h0, e});
    chk({tag, "_dat"}, dat, d);
  endtask

  task automatic load(input logic [9:0] a, input logic [15:0] d);
    ldr_we = 1'b1; ldr_adr = a; ldr_dat = d;
    tick();
    ldr_we = 1'b0;
  endtask

  task automatic set_wait(input logic [3:0] w);
    wst_we = 1'b1; wst_dat = w;
    tick();
    wst_we = 1'b0;
  endtask

  task automatic strobe(input logic [14:0] a);
    adr = a; cyc = 1'b1; stb = 1'b1;
  endtask

  task automatic drop();
    cyc = 1'b0; stb = 1'b0;
  endtask

  initial begin
    tick(); tick();
    outs("reset", 1'b0, 1'b0, 16'h0000);
    res = 1'b1;
    load(10'd0, 16'h1234);
    load(10'd1, 16'h5678);
    load(10'd2, 16'hABCD);
    outs("idle", 1'b0, 1'b0, 16'h0000);

    // wait 0: ack on the cycle after sampling, one cycle wide
    strobe(15'd0); tick();
    outs("w0_ack", 1'b1, 1'b0, 16'h1234);
    drop(); tick();
    outs("w0_after", 1'b0, 1'b0, 16'h0000);

    // wait 3 with strobe held: three quiet cycles then ack
    set_wait(4'd3);
    strobe(15'd1);
    for (int i = 0; i < 3; i++) begin tick(); outs("w3_wait", 1'b0, 1'b0, 16'h0000); end
    tick();
    outs("w3_ack", 1'b1, 1'b0, 16'h5678);
    drop(); tick();
    outs("w3_after", 1'b0, 1'b0, 16'h0000);

    // wait 5, abort after two cycles, then a full access
    set_wait(4'd5);
    strobe(15'd0); tick(); tick();
    outs("abort_wait", 1'b0, 1'b0, 16'h0000);
    drop();
    for (int i = 0; i < 6; i++) begin tick(); outs("abort_none", 1'b0, 1'b0, 16'h0000); end
    strobe(15'd0);
    for (int i = 0; i < 5; i++) begin tick(); outs("w5_wait", 1'b0, 1'b0, 16'h0000); end
    tick();
    outs("w5_ack", 1'b1, 1'b0, 16'h1234);
    drop(); tick();

    // wait register rewritten while a wait-4 fetch is in flight
    set_wait(4'd4);
    strobe(15'd2); tick();
    wst_we = 1'b1; wst_dat = 4'd0;
    tick();
    wst_we = 1'b0;
    outs("inflight_w1", 1'b0, 1'b0, 16'h0000);
    tick(); tick();
    outs("inflight_w3", 1'b0, 1'b0, 16'h0000);
    tick();
    outs("inflight_ack", 1'b1, 1'b0, 16'hABCD);
    drop(); tick();
    strobe(15'd1); tick();
    outs("newwait_ack", 1'b1, 1'b0, 16'h5678);
    drop(); tick();

    // back-to-back with wait 0: one access per two cycles
    strobe(15'd2); tick();
    outs("b2b_1", 1'b1, 1'b0, 16'hABCD);
    tick();
    outs("b2b_gap", 1'b0, 1'b0, 16'h0000);
    tick();
    outs("b2b_2", 1'b1, 1'b0, 16'hABCD);
    drop(); tick();

    // reset during WAIT aborts, store survives, wait register reloads to 0
    set_wait(4'd3);
    strobe(15'd0); tick(); tick();
    res = 1'b0; tick();
    outs("rst_mid", 1'b0, 1'b0, 16'h0000);
    tick();
    outs("rst_hold", 1'b0, 1'b0, 16'h0000);
    res = 1'b1; drop(); tick();
    outs("rst_rel", 1'b0, 1'b0, 16'h0000);
    strobe(15'd0); tick();
    outs("rst_store", 1'b1, 1'b0, 16'h1234);
    drop(); tick();

    // loader write on the ACK-entry edge returns old data
    strobe(15'd1);
    ldr_we = 1'b1; ldr_adr = 10'd1; ldr_dat = 16'h9999;
    tick();
    ldr_we = 1'b0;
    outs("ldr_race", 1'b1, 1'b0, 16'h5678);
    drop(); tick();
    strobe(15'd1); tick();
    outs("ldr_new", 1'b1, 1'b0, 16'h9999);
    drop(); tick();

    // address beyond the store
    strobe(15'h0400); tick();
`ifdef INS_RESPONDER_ERR_EN
    outs("oor_err", 1'b0, 1'b1, 16'h0000);
`else
    outs("oor_alias", 1'b1, 1'b0, 16'h1234);
`endif
    drop(); tick();
    outs("oor_after", 1'b0, 1'b0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ins_responder.md
INS_RESPONDER -- requirements
Module: ins_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, giving log2 of the word count of the internal instruction store.
REQ-002 SHALL have parameter RESET_WAIT, default 4'd0, giving the wait-state count loaded into the wait register at reset.
REQ-003 SHALL have port sys_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port sys_res_i  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port ins_adr_i  input  15  word address [15:1] from the fetching CPU.
REQ-006 SHALL have port ins_cyc_i  input  1  CPU holds the bus.
REQ-007 SHALL have port shr_stb_i  input  1  CPU requests a transaction.
REQ-008 SHALL have port ins_dat_o  output  16  instruction word.
REQ-009 SHALL have port shr_ack_o  output  1  transaction complete; ins_dat_o valid.
REQ-010 SHALL have port shr_err_o  output  1  transaction rejected (see Configuration).
REQ-011 SHALL have port ldr_we_i  input  1  boot-loader write enable.
REQ-012 SHALL have port ldr_adr_i  input  DEPTH_LOG2  boot-loader word address.
REQ-013 SHALL have port ldr_dat_i  input  16  boot-loader write data.
REQ-014 SHALL have port wst_we_i  input  1  load the wait register from wst_dat_i.
REQ-015 SHALL have port wst_dat_i  input  4  new wait-state count, 0..15.

Function
REQ-016 SHALL implement states IDLE, WAIT, ACK.
REQ-017 In IDLE with ins_cyc_i=1 and shr_stb_i=1, SHALL latch ins_adr_i, load the down-counter from the wait register, and go to WAIT if the count is nonzero, else ACK.
REQ-018 In WAIT, SHALL decrement the counter each cycle and go to ACK on the edge where it reaches 0.
REQ-019 SHALL capture store data for the latched address on the edge entering ACK.
REQ-020 In ACK, SHALL drive shr_ack_o=1 for exactly one cycle, then return to IDLE regardless of shr_stb_i.
REQ-021 Latency SHALL be 1+W cycles from the strobe-sampling edge to shr_ack_o high, with W the wait count at sampling; throughput SHALL be one access per 2+W cycles.
REQ-022 ins_dat_o SHALL equal the captured word while shr_ack_o=1, and 16'h0000 otherwise.
REQ-023 If ins_cyc_i or shr_stb_i drops in WAIT, SHALL return to IDLE next edge with no ack (abort).
REQ-024 A wait-register write SHALL affect only transactions sampled after it; the in-flight count SHALL be unaffected.
REQ-025 ldr_we_i=1 SHALL write ldr_dat_i to ldr_adr_i on that edge in any state.
REQ-026 A loader write to the fetched address on the ACK-entry edge SHALL NOT be visible to that fetch (old data returned).
REQ-027 Store address SHALL be the latched ins_adr_i[DEPTH_LOG2:1]; with the macro undefined, higher bits SHALL be ignored (aliasing).

Reset
REQ-028 With sys_res_i=0 at an edge: state IDLE, counter 0, wait register RESET_WAIT, shr_ack_o=0, shr_err_o=0, ins_dat_o=16'h0000.
REQ-029 Reset mid-transaction SHALL abort it with no ack; store contents SHALL be preserved.

Configuration
REQ-030 With INS_RESPONDER_ERR_EN defined, a transaction whose latched ins_adr_i[15:DEPTH_LOG2+1] is nonzero SHALL complete with shr_err_o=1, shr_ack_o=0, ins_dat_o=0 at the normal ack time, for exactly one cycle.
REQ-031 With INS_RESPONDER_ERR_EN undefined, shr_err_o SHALL be constant 0 and out-of-range addresses SHALL alias per REQ-027.

Verification
REQ-032 Loader writes 16'h1234 @0, 16'h5678 @1; wait=0; strobe adr 0 -> ack high exactly one cycle, 1 cycle after sampling, data 16'h1234; ack low the following cycle.
REQ-033 wait=3, strobe held at adr 1 -> shr_ack_o low for 3 cycles, high on the 4th after sampling with 16'h5678; data 0 when ack low.
REQ-034 wait=5, strobe dropped after 2 cycles -> no ack; new strobe at adr 0 -> normal ack after 5 waits.
REQ-035 wait=4 in flight, wst_dat_i=0 written mid-WAIT -> current ack still at cycle 5; next access acks at cycle 1.
REQ-036 sys_res_i low during WAIT -> outputs 0 next edge, no ack; after release, adr 0 still returns 16'h1234.
REQ-037 ERR_EN defined, DEPTH_LOG2=10, adr 15'h0400 -> shr_err_o one cycle, ack 0; undefined -> ack with the word at adr 0.
